// File: rtl/pa_lsu_spsram64x4_ctrl_pkg.sv
// Shared types and constants for the LSU 64x4 single-port SRAM controller.
// STARVE_LIMIT is only consumed when PA_LSU_SPSRAM_ANTI_STARVE_EN is defined.
package pa_lsu_spsram64x4_ctrl_pkg;

  localparam int ADDR_WIDTH   = 6;
  localparam int DATA_WIDTH   = 4;
  localparam int SRAM_DEPTH   = 64;
  localparam int STARVE_LIMIT = 4;

  localparam logic                  CEN_IDLE = 1'b1;
  localparam logic [DATA_WIDTH-1:0] WEN_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ST_RST_WAIT = 2'd0,
    ST_INIT     = 2'd1,
    ST_RUN      = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pa_lsu_spsram64x4_ctrl_if.sv
// Bus between the LSU requesters / SRAM macro (master) and the controller (slave).
interface pa_lsu_spsram64x4_ctrl_if;
  import pa_lsu_spsram64x4_ctrl_pkg::*;

  // Requests are levels held until granted; a grant is combinational in the
  // same cycle, and rd_vld/rd_data follow exactly one cycle after rd_gnt.
  logic                  flush_req;
  logic                  ctrl_busy;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_gnt;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  modport master (
    output flush_req, wr_req, wr_addr, wr_data, wr_mask, rd_req, rd_addr, sram_q,
    input  ctrl_busy, wr_gnt, rd_gnt, rd_vld, rd_data,
    input  sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );

  modport slave (
    input  flush_req, wr_req, wr_addr, wr_data, wr_mask, rd_req, rd_addr, sram_q,
    output ctrl_busy, wr_gnt, rd_gnt, rd_vld, rd_data,
    output sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );

endinterface

// File: rtl/pa_lsu_spsram64x4_ctrl_arb.sv
// Write-over-read arbiter for the single SRAM port.
// PA_LSU_SPSRAM_ANTI_STARVE_EN adds a counter that forces a read after STARVE_LIMIT write wins.
module pa_lsu_spsram64x4_ctrl_arb
  import pa_lsu_spsram64x4_ctrl_pkg::*;
(
`ifdef PA_LSU_SPSRAM_ANTI_STARVE_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic run,
  input  logic wr_req,
  input  logic rd_req,
  output logic wr_gnt,
  output logic rd_gnt
);

`ifdef PA_LSU_SPSRAM_ANTI_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          force_rd;

  assign force_rd = run & rd_req & (starve_cnt == CW'(STARVE_LIMIT));
  assign wr_gnt   = run & wr_req & ~force_rd;
  assign rd_gnt   = run & rd_req & ~wr_gnt;

  // Counts only an unbroken run of write wins over a waiting read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!run || !rd_req || rd_gnt) begin
      starve_cnt <= '0;
    end else if (wr_gnt) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  assign wr_gnt = run & wr_req;
  assign rd_gnt = run & rd_req & ~wr_req;
`endif

endmodule

// File: rtl/pa_lsu_spsram64x4_ctrl.sv
// Sequencer for the LSU 64x4 single-port SRAM: clear sweep, arbitration, pin muxing.
// Optional read anti-starvation is enabled with PA_LSU_SPSRAM_ANTI_STARVE_EN.
module pa_lsu_spsram64x4_ctrl
  import pa_lsu_spsram64x4_ctrl_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = 4'b0000
) (
  input  logic                        forever_cpuclk,
  input  logic                        cpurst_b,
  pa_lsu_spsram64x4_ctrl_if.slave     bus,
  output ctrl_state_e                 fsm_state
);

  ctrl_state_e           state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_nxt;
  logic                  rd_vld_q;
  logic                  run;
  logic                  wr_gnt;
  logic                  rd_gnt;

  assign run       = (state_q == ST_RUN);
  assign fsm_state = state_q;

  pa_lsu_spsram64x4_ctrl_arb u_arb (
`ifdef PA_LSU_SPSRAM_ANTI_STARVE_EN
    .clk    (forever_cpuclk),
    .rst_n  (cpurst_b),
`endif
    .run    (run),
    .wr_req (bus.wr_req),
    .rd_req (bus.rd_req),
    .wr_gnt (wr_gnt),
    .rd_gnt (rd_gnt)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= ST_RST_WAIT;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      rd_vld_q <= rd_gnt;
    end
  end

  // Sweep ends on the write to the last entry; the counter wraps back to 0.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_RST_WAIT: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
      ST_INIT: begin
        cnt_nxt = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(SRAM_DEPTH - 1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.flush_req) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_RST_WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A zero-mask write is still granted but leaves the SRAM idle.
  always_comb begin
    bus.sram_cen  = CEN_IDLE;
    bus.sram_gwen = 1'b1;
    bus.sram_wen  = WEN_NONE;
    bus.sram_a    = '0;
    bus.sram_d    = '0;
    if (state_q == ST_INIT) begin
      bus.sram_cen  = 1'b0;
      bus.sram_gwen = 1'b0;
      bus.sram_wen  = '0;
      bus.sram_a    = cnt_q;
      bus.sram_d    = INIT_VAL;
    end else if (wr_gnt) begin
      bus.sram_a = bus.wr_addr;
      bus.sram_d = bus.wr_data;
      if (bus.wr_mask != '0) begin
        bus.sram_cen  = 1'b0;
        bus.sram_gwen = 1'b0;
        bus.sram_wen  = ~bus.wr_mask;
      end
    end else if (rd_gnt) begin
      bus.sram_a   = bus.rd_addr;
      bus.sram_cen = 1'b0;
    end
  end

  assign bus.ctrl_busy = ~run;
  assign bus.wr_gnt    = wr_gnt;
  assign bus.rd_gnt    = rd_gnt;
  assign bus.rd_vld    = rd_vld_q;
  assign bus.rd_data   = bus.sram_q;

endmodule

// File: tb/tb_pa_lsu_spsram64x4_ctrl.sv
// Directed bench for pa_lsu_spsram64x4_ctrl with a behavioural 64x4 SRAM and a read-data scoreboard.
module tb_pa_lsu_spsram64x4_ctrl;
  import pa_lsu_spsram64x4_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  ctrl_state_e fsm_state;
  int          checks;
  int          errors;
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] mem [SRAM_DEPTH];

  pa_lsu_spsram64x4_ctrl_if bus ();

  pa_lsu_spsram64x4_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus.slave),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // Behavioural synchronous-read SRAM with active-low controls
  always @(posedge clk) begin
    if (bus.sram_cen == 1'b0) begin
      if (bus.sram_gwen == 1'b0) begin
        for (int b = 0; b < DATA_WIDTH; b++)
          if (bus.sram_wen[b] == 1'b0) mem[bus.sram_a][b] <= bus.sram_d[b];
      end else begin
        bus.sram_q <= mem[bus.sram_a];
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_write(input logic [5:0] addr, input logic [3:0] data,
                          input logic [3:0] mask, input logic [3:0] exp_wen,
                          input logic exp_cen);
    bus.wr_req  = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    bus.wr_mask = mask;
    #1;
    check("wr_gnt", 8'(bus.wr_gnt), 8'h1);
    check("wr_cen", 8'(bus.sram_cen), 8'(exp_cen));
    check("wr_wen", 8'(bus.sram_wen), 8'(exp_wen));
    tick();
    bus.wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] addr, input logic [3:0] exp_data);
    bus.rd_req  = 1'b1;
    bus.rd_addr = addr;
    #1;
    check("rd_gnt", 8'(bus.rd_gnt), 8'h1);
    check("rd_cen", 8'(bus.sram_cen), 8'h0);
    check("rd_gwen", 8'(bus.sram_gwen), 8'h1);
    check("rd_a", 8'(bus.sram_a), 8'(addr));
    exp_q.push_back(exp_data);
    tick();
    bus.rd_req = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_vld_unexpected: got data %h expected no read", bus.rd_data);
      end else begin
        check("rd_data", 8'(bus.rd_data), 8'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.flush_req = 1'b0;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_mask = '0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    #13;
    check("rst_busy", 8'(bus.ctrl_busy), 8'h1);
    check("rst_cen", 8'(bus.sram_cen), 8'h1);
    check("rst_rd_vld", 8'(bus.rd_vld), 8'h0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("wait_cen", 8'(bus.sram_cen), 8'h1);
    check("wait_busy", 8'(bus.ctrl_busy), 8'h1);

    // power-up clear sweep, with both requesters pushing to prove no grants
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    bus.wr_mask = 4'hF;
    for (int i = 0; i < SRAM_DEPTH; i++) begin
      tick();
      check("init_cen", 8'(bus.sram_cen), 8'h0);
      check("init_gwen", 8'(bus.sram_gwen), 8'h0);
      check("init_wen", 8'(bus.sram_wen), 8'h0);
      check("init_d", 8'(bus.sram_d), 8'h0);
      check("init_a", 8'(bus.sram_a), 8'(i));
      check("init_busy", 8'(bus.ctrl_busy), 8'h1);
      check("init_gnt", {6'd0, bus.wr_gnt, bus.rd_gnt}, 8'h0);
      if (i == SRAM_DEPTH - 1) begin
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
      end
    end
    tick();
    check("run_busy", 8'(bus.ctrl_busy), 8'h0);
    check("idle_cen", 8'(bus.sram_cen), 8'h1);

    // full write then read-back
    do_write(6'd5, 4'hA, 4'hF, 4'b0000, 1'b0);
    do_read(6'd5, 4'hA);

    // masked write: low two bits from 5, high two bits kept from A
    do_write(6'd5, 4'h5, 4'b0011, 4'b1100, 1'b0);
    do_read(6'd5, 4'h9);

    // zero-mask write is granted but leaves the array alone
    do_write(6'd5, 4'h0, 4'b0000, 4'b1111, 1'b1);
    do_read(6'd5, 4'h9);

    // same-address collision: write wins, read retried next cycle
    bus.wr_req = 1'b1;
    bus.wr_addr = 6'd7;
    bus.wr_data = 4'h3;
    bus.wr_mask = 4'hF;
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'd7;
    #1;
    check("col_wr_gnt", 8'(bus.wr_gnt), 8'h1);
    check("col_rd_gnt", 8'(bus.rd_gnt), 8'h0);
    tick();
    bus.wr_req = 1'b0;
    do_read(6'd7, 4'h3);

    // flush re-clears the array; grants are held off for the full sweep
    bus.flush_req = 1'b1;
    #1;
    check("flush_busy_same_cycle", 8'(bus.ctrl_busy), 8'h0);
    tick();
    bus.flush_req = 1'b0;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    for (int i = 0; i < SRAM_DEPTH; i++) begin
      check("flush_busy", 8'(bus.ctrl_busy), 8'h1);
      check("flush_gnt", {6'd0, bus.wr_gnt, bus.rd_gnt}, 8'h0);
      check("flush_a", 8'(bus.sram_a), 8'(i));
      if (i == SRAM_DEPTH - 1) begin
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
      end
      tick();
    end
    check("flush_done_busy", 8'(bus.ctrl_busy), 8'h0);
    do_read(6'd5, 4'h0);
    do_read(6'd7, 4'h0);

    // write and read both held for six cycles
    bus.wr_req = 1'b1;
    bus.wr_addr = 6'd10;
    bus.wr_data = 4'h1;
    bus.wr_mask = 4'hF;
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'd10;
    for (int c = 1; c <= 6; c++) begin
      logic exp_rd;
`ifdef PA_LSU_SPSRAM_ANTI_STARVE_EN
      exp_rd = (c == 5);
`else
      exp_rd = 1'b0;
`endif
      #1;
      check("starve_rd_gnt", 8'(bus.rd_gnt), 8'(exp_rd));
      check("starve_wr_gnt", 8'(bus.wr_gnt), 8'(!exp_rd));
      if (exp_rd) exp_q.push_back(4'h1);
      tick();
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;

    repeat (3) tick();
    check("scoreboard_drained", 8'(exp_q.size()), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pa_lsu_spsram64x4_ctrl.md
Name: pa_lsu_spsram64x4_ctrl

Overview:
Sequencer and arbiter for one 64-entry x 4-bit single-port SRAM in the LSU (CEN, GWEN and WEN active-low; synchronous read).
- Runs a hardware clear sweep after reset and on flush.
- Shares the single port between one write requester and one read requester.
- Returns read data one cycle after grant.
- Owns every SRAM control pin; the SRAM is never driven directly by LSU logic.

Parameters:
ADDR_WIDTH, 6, SRAM address width (depth = 2^ADDR_WIDTH = 64)
DATA_WIDTH, 4, data and per-bit write-enable width
INIT_VAL, 4'b0000, value written to every entry by the clear sweep
STARVE_LIMIT, 4, consecutive write wins before a pending read is forced (only used with the optional feature)

Ports:
forever_cpuclk  in  1  clock; all state on rising edge
cpurst_b  in  1  asynchronous active-low reset
flush_req  in  1  request to re-clear the whole array
ctrl_busy  out  1  clear sweep pending or in progress; no grants while high
wr_req  in  1  write request
wr_addr  in  6  write address
wr_data  in  4  write data
wr_mask  in  4  per-bit write mask, 1 = bit written
wr_gnt  out  1  write accepted this cycle
rd_req  in  1  read request
rd_addr  in  6  read address
rd_gnt  out  1  read accepted this cycle
rd_vld  out  1  rd_data valid; high the cycle after rd_gnt
rd_data  out  4  read data
sram_a  out  6  to SRAM A
sram_cen  out  1  to SRAM CEN, 0 = access
sram_gwen  out  1  to SRAM GWEN, 0 = write
sram_wen  out  4  to SRAM WEN, 0 = bit written
sram_d  out  4  to SRAM D
sram_q  in  4  from SRAM Q

Behaviour:
- Clock and reset: single clock forever_cpuclk; reset cpurst_b is asynchronous and active-low.
- FSM states: RST_WAIT (reset state), INIT, RUN.
- Reset values: FSM=RST_WAIT, sweep counter=0, rd_vld=0, starve counter=0.
- RST_WAIT:
  - sram_cen=1, ctrl_busy=1, no grants.
  - Always goes to INIT on the next cycle.
- INIT:
  - sram_cen=0, sram_gwen=0, sram_wen=4'b0000, sram_a=counter, sram_d=INIT_VAL.
  - ctrl_busy=1; wr_gnt=rd_gnt=0 regardless of requests.
  - Counter increments every cycle. The write at counter=63 is the last; next state is RUN and the counter wraps to 0.
  - flush_req is ignored in INIT; the sweep is not restarted.
  - Duration is exactly 64 cycles.
- RUN (ctrl_busy=0):
  - Grants are combinational in the same cycle as the request.
  - The SRAM is driven combinationally from the granted request.
  - Priority: write over read. wr_gnt=wr_req. rd_gnt=rd_req & ~wr_req.
  - On a write grant: sram_a=wr_addr, sram_d=wr_data, sram_gwen=0, sram_wen=~wr_mask.
    - sram_cen=0 only if wr_mask != 0.
    - wr_mask=0 is still granted but produces no SRAM access (cen=1).
  - On a read grant: sram_a=rd_addr, sram_gwen=1, sram_wen=4'b1111, sram_cen=0.
  - No grant: sram_cen=1; sram_gwen=1 and sram_wen=4'b1111 whenever cen=1.
  - rd_vld is registered and equals rd_gnt delayed by one cycle.
  - rd_data=sram_q. It is meaningful only while rd_vld=1; the consumer must capture it that cycle.
- Same-address read and write in one cycle: the write wins. A read granted on a later cycle returns the new data; no forwarding is needed.
- flush_req in RUN: the current-cycle grants proceed normally, then the FSM enters INIT next cycle with counter=0. ctrl_busy rises that next cycle.
- Reset asserted mid-sweep or mid-read: state returns to RST_WAIT immediately, rd_vld=0, and the in-flight read is lost. A full sweep reruns after reset is released.
- Requests are level signals. A requester holds its request until it is granted; the controller never queues requests.

Optional Feature:
Macro PA_LSU_SPSRAM_ANTI_STARVE_EN.
- Defined:
  - A counter counts consecutive RUN cycles with rd_req=1 and wr_gnt=1.
  - When the counter equals STARVE_LIMIT and rd_req=1, the read is granted, wr_gnt=0, and the counter clears.
  - The counter also clears on any rd_gnt, or whenever rd_req=0.
- Not defined: strict write priority; the counter logic is absent and STARVE_LIMIT is unused.

Decomposition:
- Shared package holds:
  - FSM state encoding (RST_WAIT/INIT/RUN).
  - ADDR_WIDTH/DATA_WIDTH constants and the SRAM depth constant 64.
  - The SRAM-idle constants CEN_IDLE=1 and WEN_NONE=4'b1111.
- One natural sub-module, pa_lsu_spsram64x4_arb:
  - Contents: write/read priority logic plus the optional starvation counter.
  - Output: wr_gnt/rd_gnt.
- The top keeps the FSM, the sweep counter, SRAM pin muxing and rd_vld.

Test Plan:
- Reset release -> 1 cycle with cen=1. Then 64 cycles of cen=0, gwen=0, wen=0000, d=0000, a=0..63 in order, ctrl_busy=1 throughout. ctrl_busy=0 on cycle 66.
- RUN: write addr 5, data 4'hA, mask 4'hF; next cycle read addr 5 -> rd_gnt=1, rd_vld=1 the following cycle, rd_data=4'hA.
- Masked write to addr 5 (holding 4'hA) with data 4'h5, mask 4'b0011 -> sram_wen=4'b1100; subsequent read returns 4'h9.
- wr_req and rd_req both to addr 7 in the same cycle, write data 4'h3 -> wr_gnt=1, rd_gnt=0. Read retried next cycle returns 4'h3.
- flush_req in RUN after writes -> ctrl_busy high for 64 cycles. Requests during the sweep get no grants. A read of addr 5 afterwards returns INIT_VAL 4'h0.
- wr_req and rd_req held high for 6 cycles:
  - Macro defined: writes granted on cycles 1-4, read granted on cycle 5, write on cycle 6.
  - Macro undefined: rd_gnt stays 0 for all 6 cycles.
